// File: rtl/packet_fifo_framed.sv
// -----------------------------------------------------------------------------
// packet_fifo_framed
//
// Single-clock packet FIFO. Data words live in a block RAM; packet lengths are
// kept in a small internal length FIFO so producers never send sizes in-band.
//
// Write side: wr_en pushes words into the open packet, wr_commit closes it and
// makes it readable, wr_rollback discards it. A packet that overflows the RAM,
// or that arrives while the length FIFO is full, is dropped (wr_drop pulses).
//
// Read side: the oldest committed packet is presented with its length. Any
// word of it can be read by offset (rd_data one cycle later); rd_pop_packet
// frees the whole packet at once.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push a word into the open packet
//   wr_commit         close the open packet (same-cycle word included)
//   wr_rollback       discard the open packet (wins over commit and wr_en)
//   wr_free           registered free word count; open-packet words count used
//   wr_drop           one-cycle pulse: the packet closed last cycle was dropped
//   rd_packet_ready   a committed packet is at the head
//   rd_packet_len     head packet length in words, 0 when none
//   rd_packet_count   number of committed packets held
//   rd_en, rd_offset  read word rd_offset of the head packet
//   rd_data           registered read data, holds when rd_en is low
//   rd_pop_packet     free the head packet
// -----------------------------------------------------------------------------
module packet_fifo_framed #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int MAX_PACKETS = 64,
  localparam int ADDR_BITS  = $clog2(DEPTH),
  localparam int LF_BITS    = $clog2(MAX_PACKETS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_commit,
  input  logic                 wr_rollback,
  output logic [ADDR_BITS:0]   wr_free,
  output logic                 wr_drop,
  output logic                 rd_packet_ready,
  output logic [ADDR_BITS:0]   rd_packet_len,
  output logic [LF_BITS:0]     rd_packet_count,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_offset,
  output logic [WIDTH-1:0]     rd_data,
  input  logic                 rd_pop_packet
);

  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);
  localparam logic [LF_BITS:0]   MAXP_W  = (LF_BITS+1)'(MAX_PACKETS);

  logic [WIDTH-1:0]   ram     [DEPTH];
  logic [ADDR_BITS:0] len_mem [MAX_PACKETS];

  // Pointers carry one extra bit so full (used == DEPTH) and empty differ.
  logic [ADDR_BITS:0] wptr, wptr_committed, rptr;
  logic [LF_BITS-1:0] lf_wr, lf_rd;
  logic [LF_BITS:0]   count;
  logic               ovf;

  logic               pop_ok, wr_ok, ovf_now, commit_act, drop, push;
  logic [ADDR_BITS:0] wptr_inc, commit_len;
  logic [ADDR_BITS:0] wptr_n, wptr_committed_n, rptr_n;
  logic               ovf_n;
  logic [ADDR_BITS-1:0] rd_addr;

  assign rd_packet_count = count;
  assign rd_packet_ready = (count != '0);
  assign rd_packet_len   = (count != '0) ? len_mem[lf_rd] : '0;
  // Offset arithmetic in ADDR_BITS wraps modulo DEPTH on its own.
  assign rd_addr         = rptr[ADDR_BITS-1:0] + rd_offset;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pop_ok     = rd_pop_packet && (count != '0);
    wr_ok      = wr_en && (wr_free != '0) && !wr_rollback;
    // A word refused in the commit cycle itself still poisons the packet.
    ovf_now    = ovf || (wr_en && (wr_free == '0));
    wptr_inc   = wptr + (ADDR_BITS+1)'(wr_ok);
    commit_len = wptr_inc - wptr_committed;
    commit_act = wr_commit && !wr_rollback;
    // A full length FIFO only refuses the packet if no entry frees this cycle.
    drop       = commit_act && (ovf_now || ((count == MAXP_W) && !pop_ok));
    push       = commit_act && !drop && (commit_len != '0);

    wptr_n           = wptr_inc;
    wptr_committed_n = wptr_committed;
    ovf_n            = ovf_now;
    if (wr_rollback) begin
      wptr_n = wptr_committed;
      ovf_n  = 1'b0;
    end else if (commit_act) begin
      ovf_n = 1'b0;
      if (drop)      wptr_n           = wptr_committed;
      else if (push) wptr_committed_n = wptr_inc;
    end

    rptr_n = pop_ok ? (rptr + rd_packet_len) : rptr;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr           <= '0;
      wptr_committed <= '0;
      rptr           <= '0;
      ovf            <= 1'b0;
      lf_wr          <= '0;
      lf_rd          <= '0;
      count          <= '0;
      wr_drop        <= 1'b0;
      wr_free        <= DEPTH_W;
      rd_data        <= '0;
    end else begin
      wptr           <= wptr_n;
      wptr_committed <= wptr_committed_n;
      rptr           <= rptr_n;
      ovf            <= ovf_n;
      wr_drop        <= drop;
      // Computed from next-state pointers so wr_free is exact after each edge.
      wr_free        <= DEPTH_W - (wptr_n - rptr_n);
      if (push)   lf_wr <= lf_wr + 1'b1;
      if (pop_ok) lf_rd <= lf_rd + 1'b1;
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_en) rd_data <= ram[rd_addr];
    end
  end

  // NOTE: memories are not reset; a reset clears the pointers, which makes
  // stale contents unreachable, and keeps the arrays mappable to block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) ram[wptr[ADDR_BITS-1:0]] <= wr_data;
    if (push)  len_mem[lf_wr]           <= commit_len;
  end

endmodule

// File: tb/tb_packet_fifo_framed.sv
// -----------------------------------------------------------------------------
// tb_packet_fifo_framed
//
// Directed bench for packet_fifo_framed. Instance a uses the default geometry
// (DEPTH 1024, MAX_PACKETS 64); instance b uses DEPTH 16, MAX_PACKETS 4 for
// overflow, length-FIFO-full and wrap-around cases. Expected read data is
// pushed to a queue when a read is issued and popped when rd_data is valid.
// -----------------------------------------------------------------------------
module tb_packet_fifo_framed;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a: default geometry
  logic        a_wr_en, a_wr_commit, a_wr_rollback, a_rd_en, a_pop;
  logic [31:0] a_wr_data, a_rd_data;
  logic [10:0] a_wr_free, a_len;
  logic [9:0]  a_rd_offset;
  logic [6:0]  a_count;
  logic        a_drop, a_ready;

  // instance b: DEPTH 16, MAX_PACKETS 4
  logic        b_wr_en, b_wr_commit, b_wr_rollback, b_rd_en, b_pop;
  logic [31:0] b_wr_data, b_rd_data;
  logic [4:0]  b_wr_free, b_len;
  logic [3:0]  b_rd_offset;
  logic [2:0]  b_count;
  logic        b_drop, b_ready;

  packet_fifo_framed dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_commit(a_wr_commit),
    .wr_rollback(a_wr_rollback), .wr_free(a_wr_free), .wr_drop(a_drop),
    .rd_packet_ready(a_ready), .rd_packet_len(a_len), .rd_packet_count(a_count),
    .rd_en(a_rd_en), .rd_offset(a_rd_offset), .rd_data(a_rd_data),
    .rd_pop_packet(a_pop)
  );

  packet_fifo_framed #(.WIDTH(32), .DEPTH(16), .MAX_PACKETS(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_commit(b_wr_commit),
    .wr_rollback(b_wr_rollback), .wr_free(b_wr_free), .wr_drop(b_drop),
    .rd_packet_ready(b_ready), .rd_packet_len(b_len), .rd_packet_count(b_count),
    .rd_en(b_rd_en), .rd_offset(b_rd_offset), .rd_data(b_rd_data),
    .rd_pop_packet(b_pop)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [31:0] d, input logic c);
    a_wr_en = 1'b1; a_wr_data = d; a_wr_commit = c;
    tick();
    a_wr_en = 1'b0; a_wr_commit = 1'b0;
  endtask

  task automatic b_push(input logic [31:0] d, input logic c);
    b_wr_en = 1'b1; b_wr_data = d; b_wr_commit = c;
    tick();
    b_wr_en = 1'b0; b_wr_commit = 1'b0;
  endtask

  task automatic a_read(input logic [9:0] off, input logic [31:0] expv);
    a_rd_en = 1'b1; a_rd_offset = off;
    exp_q.push_back(expv);
    tick();
    a_rd_en = 1'b0;
    check("a_rd_data", a_rd_data, exp_q.pop_front());
  endtask

  task automatic b_read(input logic [3:0] off, input logic [31:0] expv);
    b_rd_en = 1'b1; b_rd_offset = off;
    exp_q.push_back(expv);
    tick();
    b_rd_en = 1'b0;
    check("b_rd_data", b_rd_data, exp_q.pop_front());
  endtask

  task automatic b_pop_pkt();
    b_pop = 1'b1;
    tick();
    b_pop = 1'b0;
  endtask

  initial begin
    logic [31:0] b_pkts [4];

    a_wr_en = 0; a_wr_commit = 0; a_wr_rollback = 0; a_rd_en = 0; a_pop = 0;
    a_wr_data = '0; a_rd_offset = '0;
    b_wr_en = 0; b_wr_commit = 0; b_wr_rollback = 0; b_rd_en = 0; b_pop = 0;
    b_wr_data = '0; b_rd_offset = '0;

    #23 rst_n = 1'b1;
    tick();

    // ---- reset state
    check("a_free_rst",  a_wr_free, 1024);
    check("a_ready_rst", a_ready, 0);
    check("a_len_rst",   a_len, 0);
    check("a_count_rst", a_count, 0);
    check("a_drop_rst",  a_drop, 0);
    check("a_rdata_rst", a_rd_data, 0);
    check("b_free_rst",  b_wr_free, 16);

    // ---- 4-word packet, commit on the last word
    for (int i = 0; i < 4; i++) a_push(32'hA0 + i, i == 3);
    check("a_ready_p1", a_ready, 1);
    check("a_len_p1",   a_len, 4);
    check("a_free_p1",  a_wr_free, 1020);
    check("a_count_p1", a_count, 1);
    a_read(10'd2, 32'hA2);
    a_read(10'd0, 32'hA0);
    a_pop = 1'b1; tick(); a_pop = 1'b0;
    check("a_count_pop", a_count, 0);
    check("a_len_pop",   a_len, 0);
    check("a_free_pop",  a_wr_free, 1024);

    // ---- rollback (with a discarded same-cycle word), then a 2-word packet
    for (int i = 0; i < 3; i++) a_push(32'hC0 + i, 1'b0);
    check("a_free_open", a_wr_free, 1021);
    a_wr_rollback = 1'b1; a_wr_en = 1'b1; a_wr_data = 32'hDEAD;
    tick();
    a_wr_rollback = 1'b0; a_wr_en = 1'b0;
    check("a_free_rb",  a_wr_free, 1024);
    check("a_count_rb", a_count, 0);
    a_push(32'hB0, 1'b0);
    a_push(32'hB1, 1'b1);
    check("a_len_p2",  a_len, 2);
    check("a_free_p2", a_wr_free, 1022);
    a_read(10'd0, 32'hB0);
    a_read(10'd1, 32'hB1);

    // ---- b: 17 words into a 16-word RAM, then commit -> dropped
    for (int i = 0; i < 17; i++) b_push(32'h50 + i, 1'b0);
    check("b_free_full", b_wr_free, 0);
    b_wr_commit = 1'b1; tick(); b_wr_commit = 1'b0;
    check("b_drop_ovf",  b_drop, 1);
    check("b_count_ovf", b_count, 0);
    check("b_free_ovf",  b_wr_free, 16);
    tick();
    check("b_drop_once", b_drop, 0);

    // ---- b: length FIFO full
    for (int k = 0; k < 4; k++) b_push(32'h10 + k, 1'b1);
    check("b_count_4",  b_count, 4);
    check("b_free_4",   b_wr_free, 12);
    b_push(32'h14, 1'b1);
    check("b_drop_lf",  b_drop, 1);
    check("b_count_lf", b_count, 4);
    check("b_free_lf",  b_wr_free, 12);
    b_pop = 1'b1; b_push(32'h15, 1'b1); b_pop = 1'b0;
    check("b_drop_pc",  b_drop, 0);
    check("b_count_pc", b_count, 4);
    check("b_free_pc",  b_wr_free, 12);
    b_pkts[0] = 32'h11; b_pkts[1] = 32'h12; b_pkts[2] = 32'h13; b_pkts[3] = 32'h15;
    for (int k = 0; k < 4; k++) begin
      check("b_len_drain", b_len, 1);
      b_read(4'd0, b_pkts[k]);
      b_pop_pkt();
    end
    check("b_count_drain", b_count, 0);
    check("b_free_drain",  b_wr_free, 16);

    // ---- b: three 7-word packets crossing the RAM boundary
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 7; j++) b_push(32'h100 * (p + 1) + j, j == 6);
      check("b_len_wrap",  b_len, 7);
      check("b_free_wrap", b_wr_free, 9);
      for (int j = 0; j < 7; j++) b_read(4'(j), 32'h100 * (p + 1) + j);
      b_pop_pkt();
    end
    check("b_count_wrap_end", b_count, 0);
    check("b_free_wrap_end",  b_wr_free, 16);

    // ---- a: two packets queued plus an open one, then asynchronous reset
    for (int i = 0; i < 3; i++) a_push(32'hD0 + i, i == 2);
    check("a_count_q2", a_count, 2);
    check("a_free_q2",  a_wr_free, 1019);
    a_push(32'hF0, 1'b0);
    a_push(32'hF1, 1'b0);
    check("a_free_open2", a_wr_free, 1017);
    #3 rst_n = 1'b0;
    #1;
    check("a_ready_arst", a_ready, 0);
    check("a_len_arst",   a_len, 0);
    check("a_count_arst", a_count, 0);
    check("a_free_arst",  a_wr_free, 1024);
    check("a_rdata_arst", a_rd_data, 0);
    check("a_drop_arst",  a_drop, 0);
    check("b_free_arst",  b_wr_free, 16);
    #2 rst_n = 1'b1;
    tick();
    a_push(32'hE0, 1'b1);
    check("a_count_post", a_count, 1);
    check("a_len_post",   a_len, 1);
    check("a_free_post",  a_wr_free, 1023);
    a_read(10'd0, 32'hE0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
